// File: rtl/nokia_ctrl.sv
`timescale 1ns/1ps
// Nokia 5110 (PCD8544) controller: panel reset, init command sequence, then full-frame pushes.
// Latency: one byte per SPI handshake (LOAD, START, WAIT_HI, WAIT_LO) plus one FETCH cycle per data byte.
// Backpressure: spi_start is held off while spi_busy=1; each byte waits for busy to rise and then fall.
module nokia_ctrl #(
  parameter int RST_CYCLES = 1000,
  parameter int FB_BYTES   = 504
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh,
  input  logic [6:0] contrast,
  output logic       spi_start,
  output logic [7:0] spi_data,
  output logic       spi_command,
  input  logic       spi_busy,
  output logic       lcd_rst_n,
  output logic [8:0] fb_addr,
  input  logic [7:0] fb_data,
  output logic       ready,
  output logic       frame_done
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
  localparam logic [8:0]     FB_LAST  = 9'(FB_BYTES - 1);

  localparam logic [3:0] RST_HOLD = 4'd0;
  localparam logic [3:0] INIT     = 4'd1;
  localparam logic [3:0] IDLE     = 4'd2;
  localparam logic [3:0] HDR      = 4'd3;
  localparam logic [3:0] FETCH    = 4'd4;
  localparam logic [3:0] LOAD     = 4'd5;
  localparam logic [3:0] START    = 4'd6;
  localparam logic [3:0] WAIT_HI  = 4'd7;
  localparam logic [3:0] WAIT_LO  = 4'd8;

  // Which sequencing state owns the byte currently in the SPI handshake.
  localparam logic [1:0] SRC_INIT = 2'd0;
  localparam logic [1:0] SRC_HDR  = 2'd1;
  localparam logic [1:0] SRC_DATA = 2'd2;

  logic [3:0]     state;
  logic [1:0]     src;
  logic [2:0]     seq_idx;
  logic [RCW-1:0] rst_cnt;
  logic           pending;
  logic [6:0]     contrast_q;
  logic [7:0]     init_byte;
  logic [7:0]     hdr_byte;

  // Init command table: extended set, Vop, temp coeff, bias, basic set, normal display.
  always_comb begin
    init_byte = 8'h0C;
    case (seq_idx)
      3'd0:    init_byte = 8'h21;
      3'd1:    init_byte = {1'b1, contrast_q};
      3'd2:    init_byte = 8'h04;
      3'd3:    init_byte = 8'h14;
      3'd4:    init_byte = 8'h20;
      default: init_byte = 8'h0C;
    endcase
  end

  // Frame header: set Y=0 then X=0.
  assign hdr_byte = seq_idx[0] ? 8'h80 : 8'h40;

  // Start is gated by busy so a new byte can never be launched over a running one.
  assign spi_start = (state == START) && !spi_busy;
  assign ready     = (state == IDLE);

  // Main sequencer: panel reset hold, init bytes, header bytes, framebuffer bytes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RST_HOLD;
      src         <= SRC_INIT;
      seq_idx     <= 3'd0;
      rst_cnt     <= '0;
      pending     <= 1'b0;
      contrast_q  <= 7'd0;
      spi_data    <= 8'h00;
      spi_command <= 1'b0;
      lcd_rst_n   <= 1'b0;
      fb_addr     <= 9'd0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // Refresh requests accumulate into one flag; frame start overrides below.
      pending    <= pending | refresh;
      case (state)
        RST_HOLD: begin
          if (rst_cnt == RST_LAST) begin
            lcd_rst_n  <= 1'b1;
            contrast_q <= contrast;
            seq_idx    <= 3'd0;
            state      <= INIT;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        INIT: begin
          if (seq_idx == 3'd6) begin
            state <= IDLE;
          end else begin
            src   <= SRC_INIT;
            state <= LOAD;
          end
        end
        IDLE: begin
          if (pending) begin
            pending <= 1'b0;
            seq_idx <= 3'd0;
            state   <= HDR;
          end
        end
        HDR: begin
          if (seq_idx == 3'd2) begin
            fb_addr <= 9'd0;
            state   <= FETCH;
          end else begin
            src   <= SRC_HDR;
            state <= LOAD;
          end
        end
        FETCH: begin
          src   <= SRC_DATA;
          state <= LOAD;
        end
        LOAD: begin
          case (src)
            SRC_INIT: begin
              spi_data    <= init_byte;
              spi_command <= 1'b0;
            end
            SRC_HDR: begin
              spi_data    <= hdr_byte;
              spi_command <= 1'b0;
            end
            default: begin
              spi_data    <= fb_data;
              spi_command <= 1'b1;
            end
          endcase
          state <= START;
        end
        START: begin
          if (!spi_busy) state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (spi_busy) state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!spi_busy) begin
            case (src)
              SRC_INIT: begin
                seq_idx <= seq_idx + 3'd1;
                state   <= INIT;
              end
              SRC_HDR: begin
                seq_idx <= seq_idx + 3'd1;
                state   <= HDR;
              end
              default: begin
                if (fb_addr == FB_LAST) begin
                  frame_done <= 1'b1;
                  if (pending || refresh) begin
                    pending <= 1'b0;
                    seq_idx <= 3'd0;
                    state   <= HDR;
                  end else begin
                    state <= IDLE;
                  end
                end else begin
                  fb_addr <= fb_addr + 9'd1;
                  state   <= FETCH;
                end
              end
            endcase
          end
        end
        default: state <= RST_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_nokia_ctrl.sv
`timescale 1ns/1ps
// Bench for nokia_ctrl: randomized framebuffer contents and SPI timing, scoreboard of expected bytes.
// Expected byte stream is built from the command table and framebuffer snapshot when stimulus is issued.
// A monitor pops and compares on every spi_start; an SPI model checks data stability while busy.
module tb_nokia_ctrl;

  localparam int RST_CYC = 16;
  localparam int FB_N    = 504;
  localparam int BUDGET  = 30000;

  typedef struct packed {
    logic       cmd;
    logic [7:0] dat;
    logic       hdr;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       refresh;
  logic [6:0] contrast;
  logic       spi_start;
  logic [7:0] spi_data;
  logic       spi_command;
  logic       spi_busy;
  logic       lcd_rst_n;
  logic [8:0] fb_addr;
  logic [7:0] fb_data;
  logic       ready;
  logic       frame_done;

  logic [7:0] mem [0:511];

  exp_t q[$];
  int   vec;
  int   err;
  bit   pend_model;
  int   data_seen;
  int   frames;
  int   base;

  nokia_ctrl #(.RST_CYCLES(RST_CYC), .FB_BYTES(FB_N)) dut (
    .clk(clk), .reset(reset), .refresh(refresh), .contrast(contrast),
    .spi_start(spi_start), .spi_data(spi_data), .spi_command(spi_command),
    .spi_busy(spi_busy), .lcd_rst_n(lcd_rst_n), .fb_addr(fb_addr),
    .fb_data(fb_data), .ready(ready), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous framebuffer read: data valid the cycle after the address.
  always @(posedge clk) fb_data <= mem[fb_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_byte(input logic cmd, input logic [7:0] dat, input logic hdr);
    exp_t e;
    e.cmd = cmd;
    e.dat = dat;
    e.hdr = hdr;
    q.push_back(e);
  endtask

  task automatic push_init();
    push_byte(1'b0, 8'h21, 1'b0);
    push_byte(1'b0, {1'b1, contrast}, 1'b0);
    push_byte(1'b0, 8'h04, 1'b0);
    push_byte(1'b0, 8'h14, 1'b0);
    push_byte(1'b0, 8'h20, 1'b0);
    push_byte(1'b0, 8'h0C, 1'b0);
  endtask

  task automatic push_frame();
    push_byte(1'b0, 8'h40, 1'b1);
    push_byte(1'b0, 8'h80, 1'b0);
    for (int i = 0; i < FB_N; i++) push_byte(1'b1, mem[i], 1'b0);
  endtask

  // Reference rule: a refresh owes one frame unless one is already owed and not yet begun.
  task automatic pulse_refresh();
    @(negedge clk);
    refresh = 1'b1;
    if (!pend_model) begin
      push_frame();
      pend_model = 1'b1;
    end
    @(negedge clk);
    refresh = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_lcd_rst_n",   32'(lcd_rst_n),   32'd0);
    check("rst_spi_start",   32'(spi_start),   32'd0);
    check("rst_spi_data",    32'(spi_data),    32'd0);
    check("rst_spi_command", 32'(spi_command), 32'd0);
    check("rst_fb_addr",     32'(fb_addr),     32'd0);
    check("rst_ready",       32'(ready),       32'd0);
    check("rst_frame_done",  32'(frame_done),  32'd0);
  endtask

  // Called at a negedge with reset low; releases and measures the panel reset width.
  task automatic do_release();
    int n;
    push_init();
    reset = 1'b1;
    n = 0;
    while (lcd_rst_n == 1'b0 && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check("lcd_rst_low_cycles", 32'(n), 32'(RST_CYC));
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < BUDGET) begin
      n++;
      @(negedge clk);
    end
    check(name, 32'(ready), 32'd1);
  endtask

  task automatic wait_frames(input int target, input string name);
    int n;
    n = 0;
    while (frames < target && n < BUDGET) begin
      n++;
      @(negedge clk);
    end
    check(name, 32'(frames), 32'(target));
  endtask

  task automatic wait_data(input int target, input string name);
    int n;
    n = 0;
    while (data_seen < target && n < BUDGET) begin
      n++;
      @(negedge clk);
    end
    check(name, 32'(data_seen), 32'(target));
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
  endtask

  initial begin
    reset      = 1'b1;
    refresh    = 1'b0;
    contrast   = 7'h3F;
    spi_busy   = 1'b0;
    vec        = 0;
    err        = 0;
    pend_model = 1'b0;
    data_seen  = 0;
    frames     = 0;
    for (int i = 0; i < 512; i++) mem[i] = 8'(i);
    #2 reset = 1'b0;

    fork
      // Monitor: every start pops one expected byte.
      forever begin
        exp_t e;
        @(negedge clk);
        if (reset) begin
          if (spi_start) begin
            check("start_while_busy", 32'(spi_busy), 32'd0);
            if (q.size() == 0) begin
              vec++;
              err++;
              $display("FAIL unexpected_byte: got start cmd=%0d data=%02h, required no start", spi_command, spi_data);
            end else begin
              e = q.pop_front();
              check("spi_byte", {23'd0, spi_command, spi_data}, {23'd0, e.cmd, e.dat});
              if (e.hdr) begin
                pend_model = 1'b0;
                data_seen  = 0;
              end
              if (e.cmd) data_seen++;
            end
          end
          if (frame_done) frames++;
        end
      end
      // SPI slave model: random busy-rise delay and busy length; data must hold while busy.
      forever begin
        logic [7:0] cap;
        int d;
        int len;
        bit abort;
        bit stable;
        @(negedge clk);
        if (reset && spi_start) begin
          cap    = spi_data;
          d      = $urandom_range(1, 4);
          len    = spi_command ? $urandom_range(2, 12) : 20;
          abort  = 1'b0;
          stable = 1'b1;
          for (int k = 0; k < d; k++) begin
            @(negedge clk);
            if (!reset) begin
              abort = 1'b1;
              break;
            end
            if (spi_data !== cap) stable = 1'b0;
          end
          if (!abort) begin
            spi_busy = 1'b1;
            for (int k = 0; k < len; k++) begin
              @(negedge clk);
              if (!reset) begin
                abort = 1'b1;
                break;
              end
              if (spi_data !== cap) stable = 1'b0;
            end
          end
          spi_busy = 1'b0;
          if (!abort) check("spi_data_stable", 32'(stable), 32'd1);
        end
      end
    join_none

    // Power-up: reset values, panel reset width, init bytes, ready.
    repeat (3) @(negedge clk);
    check_reset_outputs();
    do_release();
    wait_ready("init_ready");
    check("init_queue_empty", 32'(q.size()), 32'd0);

    // One frame with fb_data = addr[7:0].
    base = frames;
    pulse_refresh();
    @(negedge clk);
    check("ready_drops", 32'(ready), 32'd0);
    wait_frames(base + 1, "frame1_done");
    @(negedge clk);
    check("frame1_ready", 32'(ready), 32'd1);
    repeat (50) @(negedge clk);
    check("frame1_count", 32'(frames), 32'(base + 1));
    check("frame1_queue_empty", 32'(q.size()), 32'd0);

    // Re-init with new contrast; three refreshes during INIT give one frame.
    randomize_mem();
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    pend_model = 1'b0;
    contrast = 7'($urandom_range(0, 127));
    repeat (3) @(negedge clk);
    check_reset_outputs();
    base = frames;
    do_release();
    repeat (5) @(negedge clk);
    pulse_refresh();
    repeat (30) @(negedge clk);
    pulse_refresh();
    repeat (30) @(negedge clk);
    pulse_refresh();
    wait_frames(base + 1, "init_refresh_frame");
    repeat (2000) @(negedge clk);
    check("init_refresh_count", 32'(frames), 32'(base + 1));
    check("init_refresh_queue_empty", 32'(q.size()), 32'd0);
    check("init_refresh_ready", 32'(ready), 32'd1);

    // Refresh at data byte 100 causes exactly one more frame.
    randomize_mem();
    base = frames;
    data_seen = 0;
    pulse_refresh();
    wait_data(100, "reach_byte_100");
    pulse_refresh();
    wait_frames(base + 2, "midframe_two_frames");
    repeat (2000) @(negedge clk);
    check("midframe_count", 32'(frames), 32'(base + 2));
    check("midframe_queue_empty", 32'(q.size()), 32'd0);
    check("midframe_ready", 32'(ready), 32'd1);

    // Reset at data byte 250: immediate abort, full re-init, no frame without refresh.
    randomize_mem();
    data_seen = 0;
    pulse_refresh();
    wait_data(250, "reach_byte_250");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs();
    q.delete();
    pend_model = 1'b0;
    repeat (5) @(negedge clk);
    base = frames;
    do_release();
    wait_ready("reinit_ready");
    repeat (600) @(negedge clk);
    check("no_frame_after_reset", 32'(frames), 32'(base));
    check("reinit_queue_empty", 32'(q.size()), 32'd0);
    check("reinit_ready_held", 32'(ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/nokia_ctrl.md
NOKIA_CTRL -- requirements
Module: nokia_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 1000: clk cycles lcd_rst_n is held low after reset release.
REQ-002 SHALL have parameter FB_BYTES, default 504: bytes per frame (84x48/8).
REQ-003 SHALL have port clk  in  1  system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port refresh  in  1  single-cycle request for a full frame transfer.
REQ-006 SHALL have port contrast  in  7  Vop value, sampled once during init.
REQ-007 SHALL have port spi_start  out  1  one-cycle start pulse to the SPI master.
REQ-008 SHALL have port spi_data  out  8  byte to transmit; stable from spi_start until spi_busy falls.
REQ-009 SHALL have port spi_command  out  1  DC level for the byte: 0 = command, 1 = display data.
REQ-010 SHALL have port spi_busy  in  1  SPI master busy flag.
REQ-011 SHALL have port lcd_rst_n  out  1  panel hardware reset, active-low.
REQ-012 SHALL have port fb_addr  out  9  framebuffer read address.
REQ-013 SHALL have port fb_data  in  8  framebuffer read data, valid one cycle after fb_addr.
REQ-014 SHALL have port ready  out  1  high when init is complete and no frame is in progress.
REQ-015 SHALL have port frame_done  out  1  one-cycle pulse after the last byte of a frame completes.

Function
REQ-016 SHALL implement states RST_HOLD, INIT, IDLE, HDR, FETCH, LOAD, START, WAIT_HI, WAIT_LO.
REQ-017 After reset release, RST_HOLD SHALL hold lcd_rst_n=0 for exactly RST_CYCLES cycles, then drive lcd_rst_n=1 and enter INIT.
REQ-018 INIT SHALL send six command bytes in order: 0x21, {1'b1,contrast}, 0x04, 0x14, 0x20, 0x0C. contrast is latched at INIT entry.
REQ-019 Each byte SHALL follow one handshake: LOAD drives spi_data/spi_command; START pulses spi_start for 1 cycle; WAIT_HI waits for spi_busy=1; WAIT_LO waits for spi_busy=0; control then returns to the sequencing state.
REQ-020 spi_start SHALL never be asserted while spi_busy=1.
REQ-021 After the sixth init byte completes, the block SHALL enter IDLE with ready=1.
REQ-022 A refresh pulse SHALL set a pending flag in every state. The flag clears when a frame starts.
REQ-023 In IDLE with the pending flag set, ready SHALL drop on the next cycle and HDR SHALL send 0x40 then 0x80 (Y=0, X=0), both with spi_command=0.
REQ-024 After HDR, the block SHALL send FB_BYTES data bytes with spi_command=1, addresses 0..FB_BYTES-1 ascending. For each byte, FETCH drives fb_addr and LOAD captures fb_data one cycle later.
REQ-025 fb_addr SHALL hold its value from FETCH until the byte's WAIT_LO exits, and SHALL not exceed FB_BYTES-1.
REQ-026 After data byte FB_BYTES-1 completes, frame_done SHALL pulse once. If a refresh is pending, the block SHALL go directly to HDR; otherwise it SHALL go to IDLE with ready=1.
REQ-027 A refresh arriving during RST_HOLD or INIT SHALL be retained and serviced immediately after init.
REQ-028 Multiple refresh pulses before a frame starts SHALL collapse into one frame.
REQ-029 A refresh arriving mid-frame SHALL not disturb the current frame and SHALL cause exactly one more frame.
REQ-030 Counters SHALL be sized for their parameters. The byte counter SHALL not wrap within a frame.

Reset
REQ-031 While reset=0, outputs SHALL be: lcd_rst_n=0, spi_start=0, spi_data=0x00, spi_command=0, fb_addr=0, ready=0, frame_done=0. State SHALL be RST_HOLD; pending flag and counters SHALL be 0.
REQ-032 Reset asserted mid-transfer SHALL abort immediately. After release, the full RST_HOLD and INIT sequence SHALL repeat.

Verification
REQ-033 Power-up with RST_CYCLES=16, contrast=0x3F, SPI model busy 20 cycles per byte: lcd_rst_n low 16 cycles; bytes 0x21,0xBF,0x04,0x14,0x20,0x0C with spi_command=0; then ready=1.
REQ-034 refresh pulse in IDLE with fb_data=addr[7:0]: bytes 0x40,0x80 (cmd), then 504 data bytes 0x00..0xFF,0x00..0xF7 (data); one frame_done; ready=1.
REQ-035 refresh pulsed 3 times during INIT: exactly one frame follows init.
REQ-036 refresh pulsed at data byte 100: first frame completes unchanged, then exactly one more frame, with 2 frame_done pulses total.
REQ-037 SPI model delays busy rise by 3 cycles: no second spi_start before busy falls; spi_data is stable throughout.
REQ-038 reset asserted at data byte 250: outputs go to reset values immediately; after release, the RST_HOLD and INIT sequence repeats; no frame starts without a new refresh.
